// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing,
// ALU op selection, memory handshake and an iterative mult/div stall in EXECUTA.
module unidade_controle_multiciclo #(
   parameter int unsigned LAT_MULDIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instrucao,
   input  logic        zero,
   input  logic        mem_pronto,
   output logic [1:0]  opULA,
   output logic        mem_le,
   output logic        mem_escreve,
   output logic        ir_escreve,
   output logic        pc_escreve,
   output logic        pc_desvio,
   output logic        reg_escreve,
   output logic        parado,
   output logic        erro
);

   localparam int unsigned CW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_BEQ  = 6'b000010;
   localparam logic [5:0] OP_LW   = 6'b000011;
   localparam logic [5:0] OP_SW   = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000101;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [5:0] FN_MULT = 6'b000010;
   localparam logic [5:0] FN_DIV  = 6'b000011;

   localparam logic [1:0] ULA_PASSA = 2'b00;
   localparam logic [1:0] ULA_R     = 2'b01;
   localparam logic [1:0] ULA_SUB   = 2'b10;
   localparam logic [1:0] ULA_SOMA  = 2'b11;

   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      PARADO     = 3'd5,
      ERRO       = 3'd6
   } estado_t;

   estado_t         estado_q, estado_d;
   logic [CW-1:0]   contador_q, contador_d;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       eh_r, eh_addi, eh_beq, eh_lw, eh_sw, eh_j, eh_halt, eh_legal, eh_muldiv;
   logic [1:0] ula_exec;
   logic       unused_campos;

   assign opcode        = instrucao[31:26];
   assign funct         = instrucao[5:0];
   assign unused_campos = ^instrucao[25:6];

   // Instruction decode straight from the IR contents
   always_comb begin
      eh_r      = (opcode == OP_R);
      eh_addi   = (opcode == OP_ADDI);
      eh_beq    = (opcode == OP_BEQ);
      eh_lw     = (opcode == OP_LW);
      eh_sw     = (opcode == OP_SW);
      eh_j      = (opcode == OP_J);
      eh_halt   = (opcode == OP_HALT);
      eh_legal  = eh_r | eh_addi | eh_beq | eh_lw | eh_sw | eh_j | eh_halt;
      eh_muldiv = eh_r & ((funct == FN_MULT) | (funct == FN_DIV));
      if (eh_r)        ula_exec = ULA_R;
      else if (eh_beq) ula_exec = ULA_SUB;
      else if (eh_j)   ula_exec = ULA_PASSA;
      else             ula_exec = ULA_SOMA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= BUSCA;
         contador_q <= '0;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
      end
   end

   // Next state and Moore/handshake-gated outputs; everything forced low in reset
   always_comb begin
      estado_d    = estado_q;
      contador_d  = contador_q;
      opULA       = ULA_PASSA;
      mem_le      = 1'b0;
      mem_escreve = 1'b0;
      ir_escreve  = 1'b0;
      pc_escreve  = 1'b0;
      pc_desvio   = 1'b0;
      reg_escreve = 1'b0;
      parado      = 1'b0;
      erro        = 1'b0;

      case (estado_q)
         BUSCA: begin
            mem_le = 1'b1;
            if (mem_pronto) begin
               ir_escreve = 1'b1;
               pc_escreve = 1'b1;
               estado_d   = DECODIFICA;
            end
         end
         DECODIFICA: begin
            if (!eh_legal)    estado_d = ERRO;
            else if (eh_halt) estado_d = PARADO;
            else              estado_d = EXECUTA;
         end
         EXECUTA: begin
            opULA = ula_exec;
            if (eh_muldiv) begin
               if (contador_q == CW'(LAT_MULDIV - 1)) begin
                  contador_d = '0;
                  estado_d   = ESCRITA;
               end else begin
                  contador_d = contador_q + CW'(1);
               end
            end else begin
               contador_d = '0;
               if (eh_r || eh_addi) begin
                  estado_d = ESCRITA;
               end else if (eh_lw || eh_sw) begin
                  estado_d = MEMORIA;
               end else if (eh_beq) begin
                  pc_desvio = zero;
                  estado_d  = BUSCA;
               end else if (eh_j) begin
                  pc_escreve = 1'b1;
                  estado_d   = BUSCA;
               end else begin
                  estado_d = ERRO;
               end
            end
         end
         MEMORIA: begin
            opULA       = ULA_SOMA;
            mem_le      = eh_lw;
            mem_escreve = ~eh_lw;
            if (mem_pronto) estado_d = eh_lw ? ESCRITA : BUSCA;
         end
         ESCRITA: begin
            reg_escreve = 1'b1;
            opULA       = eh_r ? ULA_R : ULA_SOMA;
            estado_d    = BUSCA;
         end
         PARADO: parado = 1'b1;
         ERRO:   erro   = 1'b1;
         default: estado_d = ERRO;
      endcase

      if (!rst_n) begin
         opULA       = ULA_PASSA;
         mem_le      = 1'b0;
         mem_escreve = 1'b0;
         ir_escreve  = 1'b0;
         pc_escreve  = 1'b0;
         pc_desvio   = 1'b0;
         reg_escreve = 1'b0;
         parado      = 1'b0;
         erro        = 1'b0;
      end
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multi-cycle control FSM: directed vector table, hand-written
// corner sequences and random instruction streams against a per-cycle trace model.
module tb_unidade_controle_multiciclo;

   localparam int unsigned LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instrucao;
   logic        zero;
   logic        mem_pronto;
   logic [1:0]  opULA;
   logic        mem_le, mem_escreve, ir_escreve, pc_escreve, pc_desvio;
   logic        reg_escreve, parado, erro;

   unidade_controle_multiciclo #(.LAT_MULDIV(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .zero(zero),
      .mem_pronto(mem_pronto), .opULA(opULA), .mem_le(mem_le),
      .mem_escreve(mem_escreve), .ir_escreve(ir_escreve), .pc_escreve(pc_escreve),
      .pc_desvio(pc_desvio), .reg_escreve(reg_escreve), .parado(parado), .erro(erro)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // {opULA, mem_le, mem_escreve, ir_escreve, pc_escreve, pc_desvio, reg_escreve, parado, erro}
   logic [9:0] obs;
   assign obs = {opULA, mem_le, mem_escreve, ir_escreve, pc_escreve, pc_desvio,
                 reg_escreve, parado, erro};

   typedef struct {
      logic       mp;
      logic [9:0] exp;
   } ciclo_t;
   ciclo_t exp_q[$];

   function automatic logic [9:0] vec(logic [1:0] u, logic le, logic we, logic ir,
                                      logic pc, logic dv, logic rg, logic pa, logic er);
      return {u, le, we, ir, pc, dv, rg, pa, er};
   endfunction

   function automatic void push(logic mp, logic [9:0] e);
      ciclo_t c;
      c.mp  = mp;
      c.exp = e;
      exp_q.push_back(c);
   endfunction

   // Expected cycle-by-cycle trace of one instruction, built from the instruction rules
   function automatic void modelo(logic [31:0] ins, logic z, int wb, int wm, int nabs);
      logic [5:0] op;
      logic [5:0] fn;
      logic [1:0] u;
      int         nex;
      op = ins[31:26];
      fn = ins[5:0];
      exp_q.delete();
      for (int i = 0; i < wb; i++) push(1'b0, vec(2'b00, 1, 0, 0, 0, 0, 0, 0, 0));
      push(1'b1, vec(2'b00, 1, 0, 1, 1, 0, 0, 0, 0));
      push(1'($urandom_range(0, 1)), 10'd0);
      if (op == 6'b111111) begin
         for (int i = 0; i < nabs; i++) push(1'($urandom_range(0, 1)), vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
         return;
      end
      if (op > 6'd5) begin
         for (int i = 0; i < nabs; i++) push(1'($urandom_range(0, 1)), vec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
         return;
      end
      u   = (op == 6'd0) ? 2'b01 : (op == 6'd2) ? 2'b10 : (op == 6'd5) ? 2'b00 : 2'b11;
      nex = (op == 6'd0 && (fn == 6'd2 || fn == 6'd3)) ? LAT : 1;
      for (int i = 0; i < nex - 1; i++) push(1'($urandom_range(0, 1)), vec(u, 0, 0, 0, 0, 0, 0, 0, 0));
      push(1'($urandom_range(0, 1)), vec(u, 0, 0, 0, (op == 6'd5), (op == 6'd2) && z, 0, 0, 0));
      if (op == 6'd3 || op == 6'd4) begin
         for (int i = 0; i <= wm; i++)
            push((i == wm), vec(2'b11, (op == 6'd3), (op == 6'd4), 0, 0, 0, 0, 0, 0));
      end
      if (op == 6'd0 || op == 6'd1 || op == 6'd3)
         push(1'($urandom_range(0, 1)), vec((op == 6'd0) ? 2'b01 : 2'b11, 0, 0, 0, 0, 0, 1, 0, 0));
   endfunction

   // Plays the modelled trace from the start of BUSCA (called right after a posedge)
   task automatic aplica(input logic [31:0] ins, input logic z, input int wb, input int wm,
                         input int nabs, input int lim, input int id,
                         output int n_le, output int n_reg, output int n_dv);
      int n;
      modelo(ins, z, wb, wm, nabs);
      n     = (lim < exp_q.size()) ? lim : exp_q.size();
      n_le  = 0;
      n_reg = 0;
      n_dv  = 0;
      for (int i = 0; i < n; i++) begin
         #1;
         instrucao  = ins;
         zero       = z;
         mem_pronto = exp_q[i].mp;
         @(negedge clk);
         total++;
         if (obs !== exp_q[i].exp) begin
            bad++;
            $display("FAIL trace id=%0d ins=%h cycle=%0d got=%b want=%b", id, ins, i, obs, exp_q[i].exp);
         end
         n_le  += int'(mem_le);
         n_reg += int'(reg_escreve);
         n_dv  += int'(pc_desvio);
         if (i < n - 1) @(posedge clk);
      end
      if (n == exp_q.size()) @(posedge clk);
   endtask

   task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nome, got, want);
      end
   endtask

   task automatic reinicia();
      @(negedge clk);
      rst_n = 1'b0;
      mem_pronto = 1'b1;
      #1 verifica("reset_outputs_zero", 32'(obs), 32'd0);
      @(negedge clk);
      #1;
      rst_n      = 1'b1;
      mem_pronto = 1'b0;
      @(posedge clk);
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        z;
      int          wb;
      int          wm;
      int          n_le;
      int          n_reg;
      int          n_dv;
   } vetor_t;

   vetor_t tab[10];
   int le_c, reg_c, dv_c;

   initial begin
      tab[0] = '{32'h0000_0000, 1'b0, 0, 0, 1, 1, 0};  // R add
      tab[1] = '{32'h0000_0002, 1'b0, 0, 0, 1, 1, 0};  // mult
      tab[2] = '{32'h0000_0003, 1'b1, 1, 0, 2, 1, 0};  // div, one fetch wait
      tab[3] = '{32'h0C00_0000, 1'b0, 3, 2, 7, 1, 0};  // LW with fetch/memory waits
      tab[4] = '{32'h1000_0000, 1'b0, 0, 1, 1, 0, 0};  // SW
      tab[5] = '{32'h0800_0000, 1'b1, 0, 0, 1, 0, 1};  // BEQ taken
      tab[6] = '{32'h0800_0000, 1'b0, 0, 0, 1, 0, 0};  // BEQ not taken
      tab[7] = '{32'h1400_0000, 1'b1, 0, 0, 1, 0, 0};  // J
      tab[8] = '{32'h0400_0000, 1'b0, 2, 0, 3, 1, 0};  // ADDI
      tab[9] = '{32'h0C00_0000, 1'b1, 0, 0, 2, 1, 0};  // LW no waits

      rst_n      = 1'b0;
      instrucao  = 32'd0;
      zero       = 1'b0;
      mem_pronto = 1'b1;
      #3 verifica("reset_async_outputs", 32'(obs), 32'd0);
      reinicia();

      foreach (tab[k]) begin
         aplica(tab[k].ins, tab[k].z, tab[k].wb, tab[k].wm, 0, 1000, k, le_c, reg_c, dv_c);
         verifica($sformatf("tab%0d_mem_le_cycles", k), 32'(le_c), 32'(tab[k].n_le));
         verifica($sformatf("tab%0d_reg_pulses", k), 32'(reg_c), 32'(tab[k].n_reg));
         verifica($sformatf("tab%0d_desvio_pulses", k), 32'(dv_c), 32'(tab[k].n_dv));
      end

      // Reset in the second EXECUTA cycle of a div, then a full div afterwards
      aplica(32'h0000_0003, 1'b0, 0, 0, 0, 3, 100, le_c, reg_c, dv_c);
      @(posedge clk);
      #1;
      mem_pronto = 1'b1;
      #1 verifica("div_exec2_before_reset", 32'(obs), 32'(vec(2'b01, 0, 0, 0, 0, 0, 0, 0, 0)));
      rst_n = 1'b0;
      #1 verifica("div_reset_immediate_zero", 32'(obs), 32'd0);
      @(negedge clk);
      verifica("div_reset_held_zero", 32'(obs), 32'd0);
      #1;
      rst_n      = 1'b1;
      mem_pronto = 1'b0;
      #1 verifica("after_reset_busca", 32'(obs), 32'(vec(2'b00, 1, 0, 0, 0, 0, 0, 0, 0)));
      @(posedge clk);
      aplica(32'h0000_0003, 1'b0, 0, 0, 0, 1000, 101, le_c, reg_c, dv_c);
      verifica("div_after_reset_reg", 32'(reg_c), 32'd1);

      // HALT and illegal opcode are absorbing until reset
      aplica(32'hFC00_0000, 1'b0, 1, 0, 12, 1000, 102, le_c, reg_c, dv_c);
      reinicia();
      aplica(32'hA800_0000, 1'b0, 0, 0, 12, 1000, 103, le_c, reg_c, dv_c);
      reinicia();

      // Random instruction stream
      for (int t = 0; t < 80; t++) begin
         logic [31:0] r;
         logic [5:0]  op;
         r  = $urandom();
         op = 6'($urandom_range(0, 5));
         r[31:26] = op;
         if (op == 6'd0 && $urandom_range(0, 2) == 0) r[5:0] = 6'($urandom_range(2, 3));
         aplica(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                0, 1000, 200 + t, le_c, reg_c, dv_c);
      end
      aplica(32'h0000_0000, 1'b0, 0, 0, 0, 1000, 999, le_c, reg_c, dv_c);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
